// File: rtl/car_pkg.sv
// Shared constants, config-word field layout and types for the car motion controller.
package car_pkg;

    localparam int COORD_W      = 11;
    localparam int SPD_MAX_W    = 4;

    localparam int CFG_X_LSB    = 0;
    localparam int CFG_Y_LSB    = 11;
    localparam int CFG_SPD_LSB  = 22;
    localparam int CFG_DIR_BIT  = 26;
    localparam int CFG_EN_BIT   = 27;
    localparam int CFG_LOAD_BIT = 28;
    localparam int CFG_USED_W   = 29;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        COMMIT = 2'd2
    } car_state_e;

    typedef struct packed {
        logic [COORD_W-1:0]   x;
        logic [COORD_W-1:0]   y;
        logic [SPD_MAX_W-1:0] spd;
        logic                 dir;
        logic                 en;
    } car_cfg_t;

endpackage

// File: rtl/car_step.sv
// Combinational next-x for one car: steps by speed left or right, wrapping at H_RES.
module car_step
    import car_pkg::*;
#(
    parameter int H_RES = 640,
    parameter int SPD_W = 4
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [SPD_W-1:0]   spd_i,
    input  logic               dir_i,
    input  logic               en_i,
    output logic [COORD_W-1:0] x_o
);

    localparam logic [COORD_W:0] HRES_EXT = (COORD_W + 1)'(H_RES);

    logic [COORD_W:0] x_ext;
    logic [COORD_W:0] spd_ext;
    logic [COORD_W:0] n;
    logic             unused_msb;

    always_comb begin
        x_ext   = {1'b0, x_i};
        spd_ext = (COORD_W + 1)'(spd_i);
        n       = x_ext;
        if (en_i && (spd_i != '0)) begin
            if (!dir_i) begin
                n = x_ext + spd_ext;
                if (n >= HRES_EXT) begin
                    n = n - HRES_EXT;
                end
            end else if (x_ext < spd_ext) begin
                n = x_ext + HRES_EXT - spd_ext;
            end else begin
                n = x_ext - spd_ext;
            end
        end
        x_o        = n[COORD_W-1:0];
        unused_msb = n[COORD_W];
    end

endmodule

// File: rtl/car_motion_ctrl.sv
// Frame-synchronous car origin stepper with atomic commit and a vblank-gated sprite-RAM write port.
// Optional build macro CAR_FRAME_CNT_EN adds a 16-bit committed-frame counter on frame_cnt.
module car_motion_ctrl
    import car_pkg::*;
#(
    parameter int  NUM_CARS = 4,
    parameter int  H_RES    = 640,
    parameter int  SPD_W    = 4,
    parameter int  ADDR     = 10,
    parameter int  CD       = 12,
    localparam int CAR_W    = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_tick,
    input  logic                        vblank,
    input  logic                        cfg_wr,
    input  logic [CAR_W-1:0]            cfg_car,
    input  logic [31:0]                 cfg_data,
    input  logic                        ram_req,
    input  logic [ADDR-1:0]             ram_addr,
    input  logic [CD-1:0]               ram_data,
    output logic                        ram_ack,
    output logic                        we,
    output logic [ADDR-1:0]             addr_w,
    output logic [CD-1:0]               pixel_in,
    output logic [NUM_CARS*COORD_W-1:0] x0_flat,
    output logic [NUM_CARS*COORD_W-1:0] y0_flat,
    output logic [NUM_CARS-1:0]         car_en,
    output logic                        busy,
    output logic [1:0]                  ovr,
    output logic [15:0]                 frame_cnt
);

    car_state_e             state_q, state_d;
    logic [CAR_W-1:0]       idx_q, idx_d;
    car_cfg_t               work_q [NUM_CARS];
    car_cfg_t               work_d [NUM_CARS];
    logic [COORD_W-1:0]     x0_q [NUM_CARS];
    logic [COORD_W-1:0]     x0_d [NUM_CARS];
    logic [COORD_W-1:0]     y0_q [NUM_CARS];
    logic [COORD_W-1:0]     y0_d [NUM_CARS];
    logic [NUM_CARS-1:0]    en_q, en_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [CAR_W-1:0]       pend_car_q, pend_car_d;
    logic [CFG_USED_W-1:0]  pend_data_q, pend_data_d;
    logic [1:0]             ovr_q, ovr_d;
    logic                   we_q, we_d;
    logic [ADDR-1:0]        addr_q, addr_d;
    logic [CD-1:0]          pixel_q, pixel_d;
    logic                   grant;
    car_cfg_t               cur_car;
    logic [COORD_W-1:0]     step_x;
    logic                   unused_cfg;

    // Speed/dir/enable always update; position only when load_pos is set.
    function automatic car_cfg_t apply_cfg(input car_cfg_t cur, input logic [CFG_USED_W-1:0] d);
        car_cfg_t nxt;
        nxt                = cur;
        nxt.spd            = '0;
        nxt.spd[SPD_W-1:0] = d[CFG_SPD_LSB +: SPD_W];
        nxt.dir            = d[CFG_DIR_BIT];
        nxt.en             = d[CFG_EN_BIT];
        if (d[CFG_LOAD_BIT]) begin
            nxt.x = d[CFG_X_LSB +: COORD_W];
            nxt.y = d[CFG_Y_LSB +: COORD_W];
        end
        return nxt;
    endfunction

    assign cur_car    = work_q[idx_q];
    assign unused_cfg = ^cfg_data[31:CFG_USED_W];

    car_step #(
        .H_RES (H_RES),
        .SPD_W (SPD_MAX_W)
    ) u_step (
        .x_i   (cur_car.x),
        .spd_i (cur_car.spd),
        .dir_i (cur_car.dir),
        .en_i  (cur_car.en),
        .x_o   (step_x)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        work_d       = work_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        en_d         = en_q;
        pend_valid_d = pend_valid_q;
        pend_car_d   = pend_car_q;
        pend_data_d  = pend_data_q;
        ovr_d        = ovr_q;

        case (state_q)
            IDLE: begin
                // A deferred write lands first so a same-cycle direct write to that car wins.
                if (pend_valid_q) begin
                    work_d[pend_car_q] = apply_cfg(work_d[pend_car_q], pend_data_q);
                    pend_valid_d       = 1'b0;
                end
                if (cfg_wr) begin
                    work_d[cfg_car] = apply_cfg(work_d[cfg_car], cfg_data[CFG_USED_W-1:0]);
                end
                if (frame_tick) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                work_d[idx_q].x = step_x;
                if (idx_q == CAR_W'(NUM_CARS - 1)) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            COMMIT: begin
                for (int i = 0; i < NUM_CARS; i++) begin
                    x0_d[i] = work_q[i].x;
                    y0_d[i] = work_q[i].y;
                    en_d[i] = work_q[i].en;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            if (frame_tick) begin
                ovr_d[0] = 1'b1;
            end
            if (cfg_wr) begin
                if (pend_valid_q) begin
                    ovr_d[1] = 1'b1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_car_d   = cfg_car;
                    pend_data_d  = cfg_data[CFG_USED_W-1:0];
                end
            end
        end
    end

    // Holding we for one cycle blocks the next grant, giving at most one write every other cycle.
    always_comb begin
        grant   = ram_req && vblank && !we_q;
        we_d    = grant;
        addr_d  = grant ? ram_addr : addr_q;
        pixel_d = grant ? ram_data : pixel_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            en_q         <= '0;
            pend_valid_q <= 1'b0;
            pend_car_q   <= '0;
            pend_data_q  <= '0;
            ovr_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            pixel_q      <= '0;
            for (int i = 0; i < NUM_CARS; i++) begin
                work_q[i] <= '0;
                x0_q[i]   <= '0;
                y0_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            en_q         <= en_d;
            pend_valid_q <= pend_valid_d;
            pend_car_q   <= pend_car_d;
            pend_data_q  <= pend_data_d;
            ovr_q        <= ovr_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            pixel_q      <= pixel_d;
            for (int i = 0; i < NUM_CARS; i++) begin
                work_q[i] <= work_d[i];
                x0_q[i]   <= x0_d[i];
                y0_q[i]   <= y0_d[i];
            end
        end
    end

`ifdef CAR_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_q == COMMIT) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_flat
        assign x0_flat[COORD_W*g +: COORD_W] = x0_q[g];
        assign y0_flat[COORD_W*g +: COORD_W] = y0_q[g];
    end

    assign car_en   = en_q;
    assign busy     = (state_q != IDLE);
    assign ovr      = ovr_q;
    assign we       = we_q;
    assign ram_ack  = we_q;
    assign addr_w   = addr_q;
    assign pixel_in = pixel_q;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Self-checking bench for car_motion_ctrl: frame commits and RAM grants are scoreboarded via expected queues.
module tb_car_motion_ctrl;

    localparam int NUM_CARS = 4;
    localparam int H_RES    = 640;
    localparam int SPD_W    = 4;
    localparam int ADDR     = 10;
    localparam int CD       = 12;
    localparam int CAR_W    = 2;
    localparam int FW       = NUM_CARS * 23;
    localparam int RW       = ADDR + CD;

    logic                   clk;
    logic                   reset_n;
    logic                   frame_tick;
    logic                   vblank;
    logic                   cfg_wr;
    logic [CAR_W-1:0]       cfg_car;
    logic [31:0]            cfg_data;
    logic                   ram_req;
    logic [ADDR-1:0]        ram_addr;
    logic [CD-1:0]          ram_data;
    logic                   ram_ack;
    logic                   we;
    logic [ADDR-1:0]        addr_w;
    logic [CD-1:0]          pixel_in;
    logic [NUM_CARS*11-1:0] x0_flat;
    logic [NUM_CARS*11-1:0] y0_flat;
    logic [NUM_CARS-1:0]    car_en;
    logic                   busy;
    logic [1:0]             ovr;
    logic [15:0]            frame_cnt;

    car_motion_ctrl #(
        .NUM_CARS (NUM_CARS),
        .H_RES    (H_RES),
        .SPD_W    (SPD_W),
        .ADDR     (ADDR),
        .CD       (CD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .vblank     (vblank),
        .cfg_wr     (cfg_wr),
        .cfg_car    (cfg_car),
        .cfg_data   (cfg_data),
        .ram_req    (ram_req),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_ack    (ram_ack),
        .we         (we),
        .addr_w     (addr_w),
        .pixel_in   (pixel_in),
        .x0_flat    (x0_flat),
        .y0_flat    (y0_flat),
        .car_en     (car_en),
        .busy       (busy),
        .ovr        (ovr),
        .frame_cnt  (frame_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [FW-1:0] exp_q[$];
    logic [RW-1:0] ram_exp_q[$];

    int m_x   [NUM_CARS];
    int m_y   [NUM_CARS];
    int m_spd [NUM_CARS];
    int m_dir [NUM_CARS];
    int m_en  [NUM_CARS];

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < NUM_CARS; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_spd[i] = 0; m_dir[i] = 0; m_en[i] = 0;
        end
    endfunction

    function automatic int model_step(input int x, input int spd, input int dir, input int en);
        if (en == 0 || spd == 0) return x;
        if (dir == 0) return (x + spd) % H_RES;
        return (x + H_RES - spd) % H_RES;
    endfunction

    function automatic void model_tick();
        for (int i = 0; i < NUM_CARS; i++) begin
            m_x[i] = model_step(m_x[i], m_spd[i], m_dir[i], m_en[i]);
        end
    endfunction

    function automatic void model_cfg(input int car, input int x, input int y, input int spd,
                                      input int dir, input int en, input int load);
        m_spd[car] = spd;
        m_dir[car] = dir;
        m_en[car]  = en;
        if (load != 0) begin
            m_x[car] = x;
            m_y[car] = y;
        end
    endfunction

    function automatic logic [FW-1:0] model_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            f[11*i +: 11]               = 11'(m_x[i]);
            f[NUM_CARS*11 + 11*i +: 11] = 11'(m_y[i]);
            f[NUM_CARS*22 + i]          = 1'(m_en[i]);
        end
        return f;
    endfunction

    function automatic logic [31:0] make_data(input int x, input int y, input int spd,
                                              input int dir, input int en, input int load);
        logic [31:0] d;
        d        = '0;
        d[10:0]  = 11'(x);
        d[21:11] = 11'(y);
        d[25:22] = 4'(spd);
        d[26]    = 1'(dir);
        d[27]    = 1'(en);
        d[28]    = 1'(load);
        return d;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int car, input int x, input int y, input int spd,
                             input int dir, input int en, input int load, input bit apply);
        cfg_wr   = 1'b1;
        cfg_car  = CAR_W'(car);
        cfg_data = make_data(x, y, spd, dir, en, load);
        if (apply) model_cfg(car, x, y, spd, dir, en, load);
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Waits for busy to drop; elapsed = cycles already spent since the tick edge.
    task automatic finish_frame(input string name, input int elapsed);
        logic [FW-1:0] prev;
        logic [FW-1:0] got;
        logic [FW-1:0] exp;
        int cnt;
        prev = {car_en, y0_flat, x0_flat};
        cnt  = elapsed;
        while (busy === 1'b1 && cnt < 20) begin
            if (cnt == NUM_CARS) begin
                checks++;
                if ({car_en, y0_flat, x0_flat} !== prev) begin
                    errors++;
                    $display("FAIL %s_early_commit: got %h required %h", name,
                             {car_en, y0_flat, x0_flat}, prev);
                end
            end
            step();
            cnt++;
        end
        checks++;
        if (cnt !== NUM_CARS + 1) begin
            errors++;
            $display("FAIL %s_busy_len: got %0d required %0d", name, cnt, NUM_CARS + 1);
        end
        got = {car_en, y0_flat, x0_flat};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_frame: got %h required <queued frame, queue empty>", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_frame: got %h required %h", name, got, exp);
            end
        end
    endtask

    task automatic run_frame(input string name);
        model_tick();
        exp_q.push_back(model_frame());
        pulse_tick();
        finish_frame(name, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({x0_flat, y0_flat, car_en} !== '0) begin
            errors++;
            $display("FAIL reset_origins: got %h required 0", {x0_flat, y0_flat, car_en});
        end
        checks++;
        if ({busy, ovr, we, ram_ack, addr_w, pixel_in} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h required 0", {busy, ovr, we, ram_ack, addr_w, pixel_in});
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
        end
        reset_n = 1'b1;
        step();
        model_reset();
        run_frame("empty_tick");
    endtask

    task automatic test_step();
        cfg_write(0, 630, 40, 15, 0, 1, 1, 1'b1);
        cfg_write(1, 3, 200, 7, 1, 1, 1, 1'b1);
        run_frame("step1");
        checks++;
        if (x0_flat[10:0] !== 11'd5) begin
            errors++;
            $display("FAIL step_car0_wrap: got %0d required 5", x0_flat[10:0]);
        end
        checks++;
        if (x0_flat[21:11] !== 11'd636) begin
            errors++;
            $display("FAIL step_car1_wrap: got %0d required 636", x0_flat[21:11]);
        end
        run_frame("step2");
        // No load_pos and enable cleared: car0 must hold its position.
        cfg_write(0, 77, 0, 9, 0, 0, 0, 1'b1);
        run_frame("hold");
        checks++;
        if (x0_flat[10:0] !== 11'd20) begin
            errors++;
            $display("FAIL hold_car0: got %0d required 20", x0_flat[10:0]);
        end
    endtask

    task automatic test_wrap();
        cfg_write(0, 639, 1, 1, 0, 1, 1, 1'b1);
        cfg_write(1, 5, 2, 5, 1, 1, 1, 1'b1);
        cfg_write(2, 0, 3, 15, 1, 1, 1, 1'b1);
        cfg_write(3, 625, 4, 15, 0, 1, 1, 1'b1);
        run_frame("wrap");
        checks++;
        if (x0_flat !== {11'd0, 11'd625, 11'd0, 11'd0}) begin
            errors++;
            $display("FAIL wrap_edges: got %h required %h", x0_flat, {11'd0, 11'd625, 11'd0, 11'd0});
        end
    endtask

    task automatic test_same_cycle();
        cfg_wr     = 1'b1;
        cfg_car    = 2'd2;
        cfg_data   = make_data(100, 7, 4, 0, 1, 1);
        frame_tick = 1'b1;
        model_cfg(2, 100, 7, 4, 0, 1, 1);
        model_tick();
        exp_q.push_back(model_frame());
        step();
        cfg_wr     = 1'b0;
        frame_tick = 1'b0;
        finish_frame("same_cycle", 0);
        checks++;
        if (x0_flat[32:22] !== 11'd104) begin
            errors++;
            $display("FAIL same_cycle_car2: got %0d required 104", x0_flat[32:22]);
        end
    endtask

    task automatic test_pending();
        model_tick();
        exp_q.push_back(model_frame());
        pulse_tick();
        cfg_write(3, 200, 9, 2, 0, 1, 1, 1'b0);
        cfg_write(3, 300, 9, 2, 0, 1, 1, 1'b0);
        checks++;
        if (ovr !== 2'b10) begin
            errors++;
            $display("FAIL pending_drop_ovr: got %b required 10", ovr);
        end
        pulse_tick();
        checks++;
        if (ovr !== 2'b11) begin
            errors++;
            $display("FAIL busy_tick_ovr: got %b required 11", ovr);
        end
        finish_frame("pending_busy", 3);
        model_cfg(3, 200, 9, 2, 0, 1, 1);
        run_frame("pending_applied");
        checks++;
        if (x0_flat[43:33] !== 11'd202) begin
            errors++;
            $display("FAIL pending_car3: got %0d required 202", x0_flat[43:33]);
        end
    endtask

    task automatic wait_grant(input string name);
        logic [RW-1:0] exp;
        int cnt;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (ram_ack !== 1'b1 && cnt < 10);
        checks++;
        if (cnt !== 1 || we !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: got cycles=%0d we=%b required cycles=1 we=1", name, cnt, we);
        end
        checks++;
        if (ram_exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_data: got %h required <queued write, queue empty>", name, {addr_w, pixel_in});
        end else begin
            exp = ram_exp_q.pop_front();
            if ({addr_w, pixel_in} !== exp) begin
                errors++;
                $display("FAIL %s_data: got %h required %h", name, {addr_w, pixel_in}, exp);
            end
        end
    endtask

    task automatic new_req();
        ram_req  = 1'b1;
        ram_addr = ADDR'($urandom_range(0, (1 << ADDR) - 1));
        ram_data = CD'($urandom_range(0, (1 << CD) - 1));
        ram_exp_q.push_back({ram_addr, ram_data});
    endtask

    task automatic test_ram();
        int bad;
        vblank = 1'b0;
        new_req();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (we !== 1'b0 || ram_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ram_no_blank: got %0d grant cycles required 0", bad);
        end
        vblank = 1'b1;
        wait_grant("ram_first");
        // Request held straight after the ack: one idle cycle, then the next grant.
        new_req();
        step();
        checks++;
        if (we !== 1'b0 || ram_ack !== 1'b0) begin
            errors++;
            $display("FAIL ram_gap: got we=%b ack=%b required we=0 ack=0", we, ram_ack);
        end
        wait_grant("ram_back_to_back");
        // Blank ends with a request pending: it must wait for the next blank.
        new_req();
        vblank = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (we !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ram_blank_fell: got %0d grant cycles required 0", bad);
        end
        vblank = 1'b1;
        wait_grant("ram_next_blank");
        ram_req = 1'b0;
        step();
        step();
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL ram_idle: got we=%b required 0", we);
        end
        vblank = 1'b0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < NUM_CARS; c++) begin
                cfg_write(c, $urandom_range(0, H_RES - 1), $urandom_range(0, 479),
                          $urandom_range(0, 15), $urandom_range(0, 1),
                          $urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
            end
            run_frame("random_a");
            run_frame("random_b");
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_cnt;
        cfg_write(1, 321, 55, 1, 0, 1, 1, 1'b1);
        run_frame("pre_reset");
        pulse_tick();
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({x0_flat, y0_flat, car_en} !== '0) begin
            errors++;
            $display("FAIL reset_mid_origins: got %h required 0", {x0_flat, y0_flat, car_en});
        end
        checks++;
        if ({busy, ovr} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_ctrl: got busy=%b ovr=%b required 0", busy, ovr);
        end
        #2;
        reset_n = 1'b1;
        step();
        model_reset();
        run_frame("after_reset1");
        run_frame("after_reset2");
        run_frame("after_reset3");
`ifdef CAR_FRAME_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        checks++;
        if (frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL frame_cnt: got %0d required %0d", frame_cnt, exp_cnt);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        vblank     = 1'b0;
        cfg_wr     = 1'b0;
        cfg_car    = '0;
        cfg_data   = '0;
        ram_req    = 1'b0;
        ram_addr   = '0;
        ram_data   = '0;
        model_reset();

        test_reset();
        test_step();
        test_wrap();
        test_same_cycle();
        test_pending();
        test_ram();
        test_random();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
